// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: geometry defaults, capture
// states and RGB565 -> RGB888 expansion (also used by VGA test patterns).
package camera_pkg;
  localparam int HPIXELS_DEF = 640;
  localparam int VPIXELS_DEF = 480;
  localparam int ADDR_W_DEF  = 20;

  // RGB565 field positions within {hi_byte, lo_byte}
  localparam int R_MSB = 15, R_LSB = 11;
  localparam int G_MSB = 10, G_LSB = 5;
  localparam int B_MSB = 4,  B_LSB = 0;

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_LO, ST_HI} capture_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // MSB replication keeps full-scale inputs at full scale (0x1F -> 0xFF)
  function automatic rgb888_t rgb565_to_rgb888(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[R_MSB:R_LSB], p[R_MSB -: 3]};
    c.g = {p[G_MSB:G_LSB], p[G_MSB -: 2]};
    c.b = {p[B_MSB:B_LSB], p[B_MSB -: 3]};
    return c;
  endfunction
endpackage

// File: rtl/cam_edge_det.sv
// Strobe-qualified edge detector: the history bit only advances on en cycles,
// so edges are seen between consecutive sampled values of the camera bus.
module cam_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     prev <= 1'b0;
    else if (en) prev <= d;
  end

  assign rise = en &  d & ~prev;
  assign fall = en & ~d &  prev;
endmodule

// File: rtl/camera_capture.sv
// Camera byte-bus capture: pairs RGB565 bytes into RGB888 pixels, produces the
// linear frame-buffer address and frame-start pulse, and flags bad geometry.
module camera_capture
  import camera_pkg::*;
#(
  parameter int HPIXELS = HPIXELS_DEF,
  parameter int VPIXELS = VPIXELS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cam_pclk_en,
  input  logic              i_cam_vsync,
  input  logic              i_cam_href,
  input  logic [7:0]        i_cam_data,
  output logic [7:0]        o_red,
  output logic [7:0]        o_green,
  output logic [7:0]        o_blue,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_valid,
  output logic              o_start_frame,
  output logic              o_frame_err
);
  localparam int COL_W = $clog2(HPIXELS + 1);
  localparam int ROW_W = $clog2(VPIXELS + 1);
  localparam logic [COL_W-1:0] H_MAX = COL_W'(HPIXELS);
  localparam logic [ROW_W-1:0] V_MAX = ROW_W'(VPIXELS);

  capture_state_e    state, state_nxt;
  logic [COL_W-1:0]  col, col_nxt;
  logic [ROW_W-1:0]  row, row_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]        hi_byte, hi_nxt;
  logic              err_set, start_nxt, emit;
  logic [1:0]        sync_in, rise, fall;
  rgb888_t           px;

  // bit 0: vsync, bit 1: href
  assign sync_in = {i_cam_href, i_cam_vsync};

  for (genvar i = 0; i < 2; i++) begin : g_edge
    cam_edge_det u_det (
      .clk (i_clk),
      .rst (i_rst),
      .en  (i_cam_pclk_en),
      .d   (sync_in[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end

  assign px = rgb565_to_rgb888({hi_byte, i_cam_data});

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    addr_nxt  = addr;
    hi_nxt    = hi_byte;
    err_set   = 1'b0;
    start_nxt = 1'b0;
    emit      = 1'b0;
    if (i_cam_pclk_en) begin
      if (fall[0]) begin
        // Frame restart wins; a coincident href rise becomes line 0
        start_nxt = 1'b1;
        err_set   = (state != ST_SYNC) && (row < V_MAX);
        col_nxt   = '0;
        row_nxt   = '0;
        addr_nxt  = '0;
        state_nxt = ST_IDLE;
        if (rise[1]) begin
          hi_nxt    = i_cam_data;
          state_nxt = ST_LO;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise[1] && !i_cam_vsync) begin
              hi_nxt    = i_cam_data;
              state_nxt = ST_LO;
            end
          end
          ST_LO, ST_HI: begin
            if (i_cam_vsync) begin
              err_set   = 1'b1;
              col_nxt   = '0;
              state_nxt = ST_IDLE;
            end else if (i_cam_href) begin
              if (state == ST_HI) begin
                hi_nxt    = i_cam_data;
                state_nxt = ST_LO;
              end else begin
                state_nxt = ST_HI;
                // Out-of-window pixels are dropped without moving the address
                if (col >= H_MAX || row >= V_MAX) begin
                  err_set = 1'b1;
                end else begin
                  emit     = 1'b1;
                  col_nxt  = col + COL_W'(1);
                  addr_nxt = addr + ADDR_W'(1);
                end
              end
            end else begin
              err_set   = (state == ST_LO) || (col != H_MAX);
              if (col != '0 && row < V_MAX) row_nxt = row + ROW_W'(1);
              col_nxt   = '0;
              state_nxt = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_SYNC;
      col           <= '0;
      row           <= '0;
      addr          <= '0;
      hi_byte       <= '0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_address     <= '0;
      o_valid       <= 1'b0;
      o_start_frame <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      col           <= col_nxt;
      row           <= row_nxt;
      addr          <= addr_nxt;
      hi_byte       <= hi_nxt;
      o_valid       <= emit;
      o_start_frame <= start_nxt;
      if (emit) begin
        o_red     <= px.r;
        o_green   <= px.g;
        o_blue    <= px.b;
        o_address <= addr;
      end
      // Error stays up through the start pulse cycle, then clears
      if (err_set)            o_frame_err <= 1'b1;
      else if (o_start_frame) o_frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_camera_capture.sv
// Randomized bench for camera_capture on a reduced 16x8 geometry; expected
// pixels and error flags come from a line/frame-level model of the camera rules.
module tb_camera_capture;
  localparam int H = 16, V = 8, AW = 8;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, vs = 1'b0, hr = 1'b0;
  logic [7:0] dat = '0;
  logic [7:0] red, green, blue;
  logic [AW-1:0] address;
  logic valid, start, ferr;

  always #5 clk = ~clk;

  camera_capture #(.HPIXELS(H), .VPIXELS(V), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_cam_pclk_en(en), .i_cam_vsync(vs),
    .i_cam_href(hr), .i_cam_data(dat), .o_red(red), .o_green(green),
    .o_blue(blue), .o_address(address), .o_valid(valid),
    .o_start_frame(start), .o_frame_err(ferr)
  );

  typedef struct packed {logic [7:0] a, r, g, b;} pix_t;
  pix_t got_q[$], exp_q[$];
  logic start_err_q[$];
  int   starts = 0, overlap = 0;

  always @(negedge clk) begin
    if (valid) got_q.push_back({address, red, green, blue});
    if (start) begin starts++; start_err_q.push_back(ferr); end
    if (valid && start) overlap++;
  end

  int checks = 0, errors = 0, gap = 1, g_idx = 0, e_idx = 0;
  int m_row = 0, m_addr = 0, s0 = 0;
  bit m_err = 0, m_in_frame = 0, exp_start_err = 0;
  int fix_q[$];

  function automatic logic [23:0] exp_rgb(input int hi, input int lo);
    int r5, g6, b5, r8, g8, b8;
    r5 = hi / 8; g6 = (hi % 8) * 8 + lo / 32; b5 = lo % 32;
    r8 = r5 * 8 + r5 / 4; g8 = g6 * 4 + g6 / 16; b8 = b5 * 8 + b5 / 4;
    return {r8[7:0], g8[7:0], b8[7:0]};
  endfunction

  function automatic int stream_diff();
    int n = 0;
    int ng = got_q.size() - g_idx;
    int ne = exp_q.size() - e_idx;
    if (ng != ne) n++;
    for (int i = 0; i < ng && i < ne; i++)
      if (got_q[g_idx + i] !== exp_q[e_idx + i]) n++;
    g_idx = got_q.size(); e_idx = exp_q.size();
    return n;
  endfunction

  function automatic logic last_start_err();
    return (start_err_q.size() != 0) ? start_err_q[start_err_q.size() - 1] : 1'bx;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); en = 1'b0; end
  endtask

  task automatic strobe(input logic v, input logic h, input int d);
    for (int i = 1; i < gap; i++) begin @(negedge clk); en = 1'b0; end
    @(negedge clk); en = 1'b1; vs = v; hr = h; dat = 8'(d);
  endtask

  task automatic frame_start(input bit merged);
    exp_start_err = m_err || (m_in_frame && m_row < V);
    s0 = starts;
    strobe(1, 0, 0); strobe(1, 0, 0);
    m_row = 0; m_addr = 0; m_err = 0; m_in_frame = 1;
    if (!merged) begin strobe(0, 0, 0); strobe(0, 0, 0); end
  endtask

  task automatic send_bytes(input int nbytes);
    int hi = 0;
    for (int b = 0; b < nbytes; b++) begin
      int d = (fix_q.size() != 0) ? fix_q.pop_front() : int'($urandom_range(0, 255));
      pix_t p;
      strobe(0, 1, d);
      if (b % 2 == 0) hi = d;
      else if (b / 2 < H && m_row < V) begin
        p.a = 8'(m_addr);
        {p.r, p.g, p.b} = exp_rgb(hi, d);
        exp_q.push_back(p);
        m_addr++;
      end
    end
  endtask

  task automatic end_line(input int nbytes);
    int emitted = (m_row < V) ? ((nbytes / 2 < H) ? nbytes / 2 : H) : 0;
    if (nbytes % 2 != 0 || nbytes / 2 != H || (m_row >= V && nbytes > 1)) m_err = 1;
    if (emitted > 0 && m_row < V) m_row++;
    strobe(0, 0, 0); strobe(0, 0, 0);
  endtask

  task automatic send_line(input int nbytes);
    send_bytes(nbytes); end_line(nbytes);
  endtask

  task automatic check_start(input string name);
    checks++;
    if (starts - s0 != 1 || last_start_err() !== exp_start_err) begin
      errors++;
      $display("FAIL %s_start: pulses=%0d err_at_start=%b, required 1 pulse with err %b",
               name, starts - s0, last_start_err(), exp_start_err);
    end
  endtask

  task automatic check_tail(input string name);
    int d = stream_diff();
    checks++;
    if (d != 0) begin errors++; $display("FAIL %s_stream: %0d pixel mismatches, required 0", name, d); end
    checks++;
    if (ferr !== m_err) begin errors++; $display("FAIL %s_err: got %b, required %b", name, ferr, m_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(3);
    checks++;
    if ({red, green, blue, address, valid, start, ferr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {red, green, blue, address, valid, start, ferr});
    end
    @(negedge clk); rst = 1'b0;
    gap = 1;
    for (int i = 0; i < 8; i++) strobe(0, 1, i * 37);
    strobe(0, 0, 0); idle(3);
    checks++;
    if (got_q.size() != g_idx || starts != 0) begin
      errors++;
      $display("FAIL reset_sync_wait: pixels=%0d starts=%0d, required 0 and 0", got_q.size() - g_idx, starts);
    end
  endtask

  task automatic test_full_frame();
    int n0 = got_q.size();
    gap = 1; frame_start(0);
    for (int l = 0; l < V; l++) send_line(2 * H);
    idle(3);
    check_start("full");
    checks++;
    if (got_q.size() - n0 != H * V || got_q.size() == 0 || got_q[got_q.size() - 1].a !== 8'(H * V - 1)) begin
      errors++;
      $display("FAIL full_count: pixels=%0d, required %0d ending at address %0d", got_q.size() - n0, H * V, H * V - 1);
    end
    check_tail("full");
  endtask

  task automatic test_colours();
    int b0 = got_q.size();
    gap = 2;
    fix_q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    frame_start(0);
    for (int l = 0; l < V; l++) send_line(2 * H);
    idle(4);
    check_start("colour");
    checks++;
    if (got_q.size() < b0 + 3 || {got_q[b0].r, got_q[b0].g, got_q[b0].b} !== 24'hFF0000 ||
        {got_q[b0+1].r, got_q[b0+1].g, got_q[b0+1].b} !== 24'h00FF00 ||
        {got_q[b0+2].r, got_q[b0+2].g, got_q[b0+2].b} !== 24'h0000FF) begin
      errors++;
      $display("FAIL colour_primaries: got %h %h %h, required ff0000 00ff00 0000ff",
               {got_q[b0].r, got_q[b0].g, got_q[b0].b}, {got_q[b0+1].r, got_q[b0+1].g, got_q[b0+1].b},
               {got_q[b0+2].r, got_q[b0+2].g, got_q[b0+2].b});
    end
    check_tail("colour");
  endtask

  task automatic test_odd_line();
    int n0 = got_q.size();
    gap = 1; frame_start(0);
    for (int l = 0; l < V; l++) send_line((l == 2) ? 2 * H - 1 : 2 * H);
    idle(3);
    check_start("odd");
    checks++;
    if (got_q.size() - n0 != H * V - 1) begin
      errors++; $display("FAIL odd_count: pixels=%0d, required %0d", got_q.size() - n0, H * V - 1);
    end
    check_tail("odd");
  endtask

  task automatic test_short_frame();
    gap = 1; frame_start(0);
    idle(2);
    checks++;
    if (ferr !== 1'b0) begin errors++; $display("FAIL short_err_cleared: got %b, required 0", ferr); end
    for (int l = 0; l < V - 2; l++) send_line(2 * H);
    idle(3);
    check_start("short");
    check_tail("short");
  endtask

  task automatic test_long_line();
    gap = 1; frame_start(0);
    for (int l = 0; l < V; l++) send_line((l == 1) ? 2 * (H + 2) : 2 * H);
    idle(3);
    check_start("long");
    check_tail("long");
  endtask

  task automatic test_vsync_abort();
    gap = 1; frame_start(0);
    send_line(2 * H);
    send_bytes(5);
    strobe(1, 1, 0);
    m_err = 1;
    idle(3);
    check_start("abort");
    check_tail("abort");
  endtask

  task automatic test_back_to_back();
    gap = 1; frame_start(1);
    for (int l = 0; l < V; l++) send_line(2 * H);
    idle(3);
    check_start("merged");
    check_tail("merged");
  endtask

  task automatic test_reset_mid_line();
    gap = 1; frame_start(0);
    send_line(2 * H); send_line(2 * H);
    send_bytes(6);
    idle(2);
    check_tail("pre_reset");
    strobe(0, 1, 8'h5A); strobe(0, 1, 8'hA5);
    @(posedge clk); #2;
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid: got %b, required 1", valid); end
    rst = 1'b1; #1;
    checks++;
    if ({red, green, blue, address, valid, start, ferr} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h, required 0", {red, green, blue, address, valid, start, ferr});
    end
    @(negedge clk); rst = 1'b0;
    m_in_frame = 0; m_err = 0;
    s0 = starts;
    for (int i = 0; i < 2 * H; i++) strobe(0, 1, int'($urandom_range(0, 255)));
    strobe(0, 0, 0); strobe(0, 0, 0);
    for (int i = 0; i < 2 * H; i++) strobe(0, 1, int'($urandom_range(0, 255)));
    strobe(0, 0, 0); idle(3);
    checks++;
    if (got_q.size() != g_idx || starts != s0) begin
      errors++;
      $display("FAIL reset_quiet: pixels=%0d starts=%0d, required 0 and 0", got_q.size() - g_idx, starts - s0);
    end
    frame_start(0);
    for (int l = 0; l < V; l++) send_line(2 * H);
    idle(3);
    checks++;
    if (got_q.size() <= g_idx || got_q[g_idx].a !== 8'd0) begin
      errors++; $display("FAIL reset_restart_addr: got %0d, required 0", got_q[g_idx].a);
    end
    check_start("restart");
    check_tail("restart");
  endtask

  task automatic test_slow_strobe();
    int n0 = got_q.size();
    gap = 3; frame_start(0);
    for (int l = 0; l < V; l++) send_line(2 * H);
    idle(8);
    check_start("slow");
    checks++;
    if (got_q.size() - n0 != H * V) begin
      errors++; $display("FAIL slow_count: pixels=%0d, required %0d", got_q.size() - n0, H * V);
    end
    check_tail("slow");
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL start_valid_overlap: got %0d, required 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_colours();
    test_odd_line();
    test_short_frame();
    test_long_line();
    test_vsync_abort();
    test_back_to_back();
    test_reset_mid_line();
    test_slow_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
